// File: rtl/uart_tx_word.sv
// Serialises one 32-bit word as four back-to-back 8N1 frames, byte 31:24 first,
// each byte MSB first, mirroring the packing of the matching word receiver.
module uart_tx_word #(
    parameter int unsigned CLKS_PER_BIT = 521
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] data,
    output logic        tx,
    output logic        busy,
    output logic        done,
    output logic [1:0]  byte_num,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StStart    = 3'd1,
        StData     = 3'd2,
        StStop     = 3'd3,
        StComplete = 3'd4
    } state_e;

    localparam logic [11:0] LastCount = 12'(CLKS_PER_BIT - 1);

    state_e      state_q, state_d;
    logic [11:0] count_q, count_d;
    logic [2:0]  bit_q, bit_d;
    logic [1:0]  byte_q, byte_d;
    logic [31:0] shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        done_q, done_d;

    logic        bit_end;
    logic [2:0]  next_bit;

    assign bit_end  = (count_q == LastCount);
    assign next_bit = bit_q + 3'd1;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                tx_d    = 1'b1;
                count_d = '0;
                bit_d   = '0;
                byte_d  = '0;
                if (start) begin
                    shift_d = data;
                    tx_d    = 1'b0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    count_d = '0;
                    bit_d   = '0;
                    // Index (3-byte)*8+7: the MSB of the current byte.
                    tx_d    = shift_q[{~byte_q, 3'd7}];
                    state_d = StData;
                end else begin
                    count_d = count_q + 12'd1;
                end
            end
            StData: begin
                if (bit_end) begin
                    count_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = StStop;
                    end else begin
                        bit_d = next_bit;
                        tx_d  = shift_q[{~byte_q, ~next_bit}];
                    end
                end else begin
                    count_d = count_q + 12'd1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    count_d = '0;
                    if (byte_q != 2'd3) begin
                        byte_d  = byte_q + 2'd1;
                        tx_d    = 1'b0;
                        state_d = StStart;
                    end else begin
                        done_d  = 1'b1;
                        state_d = StComplete;
                    end
                end else begin
                    count_d = count_q + 12'd1;
                end
            end
            StComplete: begin
                tx_d    = 1'b1;
                byte_d  = '0;
                state_d = StIdle;
            end
            default: begin
                tx_d    = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            count_q <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign byte_num = byte_q;
    assign state    = state_q;

endmodule

// File: tb/tb_uart_tx_word.sv
// Bench for uart_tx_word: a fast instance checked cycle-exactly against the 8N1 line
// format, and a default-rate instance decoded by a mid-bit sampling receiver model.
module tb_uart_tx_word;

    localparam int Fast = 8;
    localparam int Slow = 521;

    logic        clk = 1'b0;
    logic        rst;
    logic        start8, start_l;
    logic [31:0] data8, data_l;
    logic        tx8, busy8, done8, tx_l, busy_l, done_l;
    logic [1:0]  byte8, byte_l;
    logic [2:0]  state8, state_l;

    int vecs = 0;
    int errs = 0;
    int cyc = 0;
    int done_cnt_l = 0;
    int a1, a2, a3;

    always #5 clk = ~clk;

    uart_tx_word #(.CLKS_PER_BIT(Fast)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .data(data8), .tx(tx8),
        .busy(busy8), .done(done8), .byte_num(byte8), .state(state8)
    );

    uart_tx_word #(.CLKS_PER_BIT(Slow)) u_dut_l (
        .clk(clk), .rst(rst), .start(start_l), .data(data_l), .tx(tx_l),
        .busy(busy_l), .done(done_l), .byte_num(byte_l), .state(state_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to the middle of the next cycle; all sampling and driving happens there.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (done_l === 1'b1) done_cnt_l++;
    endtask

    // Line level during line bit b (0..39) of word w: start 0, 8 data bits MSB first, stop 1.
    function automatic logic exp_bit(input logic [31:0] w, input int b);
        int j = b / 10;
        int p = b % 10;
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return w[(3 - j) * 8 + (8 - p)];
    endfunction

    task automatic expect_idle8(input string tag);
        chk({tag, "_tx"}, 32'(tx8), 32'd1);
        chk({tag, "_busy"}, 32'(busy8), 32'd0);
        chk({tag, "_done"}, 32'(done8), 32'd0);
        chk({tag, "_byte"}, 32'(byte8), 32'd0);
        chk({tag, "_state"}, 32'(state8), 32'd0);
    endtask

    // mode 0: plain, 1: scramble data every cycle, 2: pulse start with all-ones in byte 2.
    task automatic send8(input logic [31:0] w, input int mode, input bit keep,
                         output int acc_cyc);
        start8  = 1'b1;
        data8   = w;
        acc_cyc = cyc;
        tick();
        if (!keep) start8 = 1'b0;
        chk("accept_state", 32'(state8), 32'd1);
        chk("accept_busy", 32'(busy8), 32'd1);
        for (int k = 0; k < 40 * Fast; k++) begin
            chk("tx_bit", 32'(tx8), 32'(exp_bit(w, k / Fast)));
            chk("byte_num", 32'(byte8), 32'(k / (10 * Fast)));
            chk("done_early", 32'(done8), 32'd0);
            if (mode == 1) data8 = $urandom;
            if (mode == 2) begin
                start8 = (k >= 170 && k < 175);
                if (k == 170) data8 = 32'hFFFF_FFFF;
            end
            tick();
        end
        // 321 cycles after the cycle in which start was accepted.
        chk("done_at_321", 32'(done8), 32'd1);
        chk("complete_state", 32'(state8), 32'd4);
        chk("complete_tx", 32'(tx8), 32'd1);
        chk("complete_busy", 32'(busy8), 32'd1);
        tick();
        chk("done_fall", 32'(done8), 32'd0);
        chk("busy_fall", 32'(busy8), 32'd0);
        chk("idle_state", 32'(state8), 32'd0);
    endtask

    // Receiver model: find each falling edge, sample mid-bit, reassemble MSB-first.
    task automatic loopback(input logic [31:0] w);
        logic [31:0] rx = '0;
        int n;
        start_l    = 1'b1;
        data_l     = w;
        done_cnt_l = 0;
        tick();
        start_l = 1'b0;
        for (int j = 0; j < 4; j++) begin
            n = 0;
            while (tx_l !== 1'b0 && n < 3 * Slow) begin
                tick();
                n++;
            end
            chk("lb_start_found", 32'(n < 3 * Slow), 32'd1);
            repeat (Slow / 2) tick();
            chk("lb_start_bit", 32'(tx_l), 32'd0);
            for (int i = 0; i < 8; i++) begin
                repeat (Slow) tick();
                rx = {rx[30:0], tx_l};
            end
            repeat (Slow) tick();
            chk("lb_stop_bit", 32'(tx_l), 32'd1);
        end
        n = 0;
        while (busy_l !== 1'b0 && n < 2 * Slow) begin
            tick();
            n++;
        end
        chk("lb_busy_end", 32'(n < 2 * Slow), 32'd1);
        repeat (3) tick();
        chk("lb_done_count", 32'(done_cnt_l), 32'd1);
        chk("lb_word", rx, w);
    endtask

    initial begin
        rst     = 1'b1;
        start8  = 1'b0;
        start_l = 1'b0;
        data8   = '0;
        data_l  = '0;
        repeat (3) tick();
        expect_idle8("por");
        rst = 1'b0;
        repeat (2) tick();
        expect_idle8("post_por");

        // Exact bit stream and done latency.
        send8(32'h1234_5678, 0, 1'b0, a1);
        repeat (2) tick();

        // Busy rejection: all-ones start pulse in byte 2 of an all-zero word.
        send8(32'h0000_0000, 2, 1'b0, a1);
        start8 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            chk("rej_no_restart_tx", 32'(tx8), 32'd1);
            chk("rej_no_done", 32'(done8), 32'd0);
            chk("rej_no_busy", 32'(busy8), 32'd0);
            tick();
        end

        // Back-to-back with start held high.
        send8(32'hA5A5_A5A5, 0, 1'b1, a1);
        send8(32'h5A5A_5A5A, 0, 1'b0, a2);
        chk("b2b_period", 32'(a2 - a1), 32'(40 * Fast + 2));
        repeat (2) tick();

        // Data changing every cycle after acceptance.
        send8(32'hCAFE_F00D, 1, 1'b0, a1);
        repeat (2) tick();

        // Randomised words.
        for (int r = 0; r < 3; r++) begin
            send8($urandom, 0, 1'b0, a3);
            repeat (1 + $urandom_range(0, 3)) tick();
        end

        // Asynchronous reset in the middle of byte 1's data bits.
        start8 = 1'b1;
        data8  = $urandom;
        tick();
        start8 = 1'b0;
        repeat (100) tick();
        chk("pre_rst_state", 32'(state8), 32'd2);
        chk("pre_rst_byte", 32'(byte8), 32'd1);
        rst = 1'b1;
        #1;
        expect_idle8("rst_async");
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_idle8("rst_hold");
        end
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            chk("rst_after_tx", 32'(tx8), 32'd1);
            chk("rst_after_busy", 32'(busy8), 32'd0);
        end

        // Default-rate loopback through the receiver model.
        loopback(32'h0000_0000);
        loopback(32'hFFFF_FFFF);
        loopback(32'h8000_0001);
        loopback(32'hDEAD_BEEF);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
